// File: rtl/muxpga_cfg_sequencer.sv
// Configuration sequencer for the cell grid: loads a nibble-wide program of
// {cfg, len} pairs, then replays it. The replay is one grid reset pulse
// followed by each cfg word held for len+1 cycles. It either stops on the
// last entry or wraps back to the first one.
module muxpga_cfg_sequencer #(
  parameter int STEPS = 8,
  parameter int CW    = 4,
  parameter int LW    = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [CW-1:0]              wr_data,
  input  logic                       wr_strobe,
  input  logic                       run,
  input  logic                       loop,
  output logic [CW-1:0]              cfg,
  output logic                       grid_reset,
  output logic [$clog2(STEPS)-1:0]   step_idx,
  output logic                       busy,
  output logic                       done
);

  localparam int SW = $clog2(STEPS);
  localparam logic [SW-1:0] IDX0 = SW'(0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GRST = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t            state_r, state_nxt;
  logic [CW-1:0]     mem_cfg_r [STEPS];
  logic [LW-1:0]     mem_len_r [STEPS];
  logic [SW:0]       wp_r;
  logic [SW:0]       cnt_r;
  logic [LW-1:0]     timer_r, timer_nxt;
  logic              strobe_prev_r;

  logic              wr_accept_s;
  logic [SW-1:0]     wr_idx_s;
  logic [SW:0]       cnt_wr_s;
  logic [SW-1:0]     last_idx_s;
  logic [SW-1:0]     step_inc_s;

  logic [CW-1:0]     cfg_nxt;
  logic              grid_reset_nxt;
  logic [SW-1:0]     step_nxt;
  logic              busy_nxt;
  logic              done_nxt;

  // Larger of two step counts; keeps cnt from shrinking on overwrite.
  function automatic logic [SW:0] max_cnt(input logic [SW:0] a, input logic [SW:0] b);
    if (a > b) begin
      return a;
    end else begin
      return b;
    end
  endfunction

  // Write qualification and derived indices.
  always_comb begin
    wr_accept_s = wr_strobe && !strobe_prev_r && (state_r == ST_IDLE);
    wr_idx_s    = wp_r[SW:1];
    cnt_wr_s    = max_cnt(cnt_r, {1'b0, wr_idx_s} + (SW+1)'(1));
    last_idx_s  = SW'(cnt_r - (SW+1)'(1));
    step_inc_s  = step_idx + SW'(1);
  end

  // Program memory, write pointer, step count and strobe edge history.
  // The strobe history resets high, so a strobe held through reset release is not a write.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_cfg_r     <= '{default: '0};
      mem_len_r     <= '{default: '0};
      wp_r          <= (SW+1)'(0);
      cnt_r         <= (SW+1)'(0);
      strobe_prev_r <= 1'b1;
    end else begin
      strobe_prev_r <= wr_strobe;
      if (wr_accept_s) begin
        if (wp_r[0] == 1'b0) begin
          mem_cfg_r[wr_idx_s] <= wr_data;
        end else begin
          mem_len_r[wr_idx_s] <= LW'(wr_data);
          cnt_r               <= cnt_wr_s;
        end
        wp_r <= wp_r + (SW+1)'(1);
      end else begin
        wp_r <= wp_r;
      end
    end
  end

  // Next state and next output values; defaults describe the IDLE/abort case.
  always_comb begin
    state_nxt      = ST_IDLE;
    timer_nxt      = LW'(0);
    cfg_nxt        = CW'(0);
    grid_reset_nxt = 1'b0;
    step_nxt       = IDX0;
    busy_nxt       = 1'b0;
    done_nxt       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // Uses the count from before any write landing in this same cycle.
        if (run && (cnt_r != (SW+1)'(0))) begin
          state_nxt      = ST_GRST;
          timer_nxt      = mem_len_r[IDX0];
          cfg_nxt        = mem_cfg_r[IDX0];
          grid_reset_nxt = 1'b1;
          busy_nxt       = 1'b1;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_GRST: begin
        if (run) begin
          state_nxt = ST_RUN;
          timer_nxt = timer_r;
          cfg_nxt   = cfg;
          busy_nxt  = 1'b1;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (!run) begin
          state_nxt = ST_IDLE;
        end else if (timer_r != LW'(0)) begin
          state_nxt = ST_RUN;
          timer_nxt = timer_r - LW'(1);
          cfg_nxt   = cfg;
          step_nxt  = step_idx;
          busy_nxt  = 1'b1;
        end else if (step_idx != last_idx_s) begin
          state_nxt = ST_RUN;
          timer_nxt = mem_len_r[step_inc_s];
          cfg_nxt   = mem_cfg_r[step_inc_s];
          step_nxt  = step_inc_s;
          busy_nxt  = 1'b1;
        end else if (loop) begin
          // Wrap to entry 0 without another grid reset pulse.
          state_nxt = ST_RUN;
          timer_nxt = mem_len_r[IDX0];
          cfg_nxt   = mem_cfg_r[IDX0];
          busy_nxt  = 1'b1;
        end else begin
          state_nxt = ST_DONE;
          cfg_nxt   = cfg;
          step_nxt  = step_idx;
          done_nxt  = 1'b1;
        end
      end
      ST_DONE: begin
        if (run) begin
          state_nxt = ST_DONE;
          cfg_nxt   = cfg;
          step_nxt  = step_idx;
          done_nxt  = 1'b1;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, hold timer and registered grid-facing outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      timer_r    <= LW'(0);
      cfg        <= CW'(0);
      grid_reset <= 1'b0;
      step_idx   <= IDX0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_r    <= state_nxt;
      timer_r    <= timer_nxt;
      cfg        <= cfg_nxt;
      grid_reset <= grid_reset_nxt;
      step_idx   <= step_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
    end
  end

endmodule
